// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   funct3_t    : RISC-V load/store width encodings
//   lsu_state_t : transaction FSM states
//   is_misaligned(): natural-alignment check for a funct3/offset pair
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        return ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory bus bundle.
//   req_*  : core request (valid, we, funct3, addr, wdata)
//   busy, resp_* : stall and completion back to the core
//   mem_*  : data-memory request/acknowledge bus
// Modports: slave = the load/store unit, master = core + memory environment.
interface load_store_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  busy;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output busy, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  busy, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   addr[1:0], funct3, we : access offset, width code and direction
//   wdata / rdata         : store data in, raw memory word in
//   be                    : byte enables (all ones for loads)
//   wdata_rep             : store data replicated across lanes (0 for loads)
//   rdata_ext             : shifted and sign/zero-extended load data (0 for stores)
//   illegal               : misaligned access or unsupported funct3
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [1:0]            addr,
    input  logic [2:0]            funct3,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata_rep,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  illegal
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  bad_f3;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = '0;
        rdata_ext = '0;
        shifted   = rdata >> {addr, 3'b000};

        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    be        = 4'b0001 << addr;
                    wdata_rep = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be        = 4'b0011 << addr;
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end else begin
            case (funct3)
                F3_B:    rdata_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
                F3_BU:   rdata_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
                F3_H:    rdata_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
                F3_HU:   rdata_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
                default: rdata_ext = shifted;
            endcase
        end

        // Stores only allow B/H/W; loads reject 011, 110 and 111.
        if (we) begin
            bad_f3 = (funct3 > 3'b010);
        end else begin
            bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        illegal = bad_f3 || is_misaligned(funct3, addr);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine between core and data memory.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : load_store_unit_if.slave carrying the core request/response
//              (req_*, busy, resp_*) and the memory bus (mem_*)
// Parameters: DATA_WIDTH (32 only), TIMEOUT (ack wait limit in cycles, 0 = none).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    lsu_state_t            state_q, state_d;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  in_idle;
    logic                  in_access;
    logic                  accept;
    logic                  timeout;
    logic [1:0]            a_addr;
    logic [2:0]            a_funct3;
    logic                  a_we;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] rdata_ext;
    logic                  illegal;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign accept    = in_idle && bus.req_valid;
    assign timeout   = (TIMEOUT != 0) && !bus.mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    // One lane unit serves both phases: in IDLE it judges the incoming request,
    // afterwards it works from the latched request.
    assign a_addr   = in_idle ? bus.req_addr[1:0] : addr_q[1:0];
    assign a_funct3 = in_idle ? bus.req_funct3    : funct3_q;
    assign a_we     = in_idle ? bus.req_we        : we_q;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .addr      (a_addr),
        .funct3    (a_funct3),
        .we        (a_we),
        .wdata     (wdata_q),
        .rdata     (bus.mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .illegal   (illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                cnt_q    <= '0;
                rdata_q  <= '0;
                err_q    <= illegal;
            end else if (in_access) begin
                if (bus.mem_ack) begin
                    rdata_q <= rdata_ext;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.busy      = !in_idle;
        bus.resp_valid = (state_q == DONE);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = illegal ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
                bus.mem_be    = be;
                bus.mem_wdata = wdata_rep;
                if (bus.mem_ack || timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit (TIMEOUT=4).
// Directed cases plus randomized transactions, each compared against a
// behavioural model of the access rules.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32)) bus ();

    load_store_unit #(
        .DATA_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    32'(bus.busy), 32'h0);
        chk({tag, "_valid"},   32'(bus.resp_valid), 32'h0);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'h0);
        chk({tag, "_mem_we"},  32'(bus.mem_we), 32'h0);
        chk({tag, "_mem_be"},  32'(bus.mem_be), 32'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    // ack_dly: cycle index within the access phase at which mem_ack is given
    // (0 = same cycle mem_req first rises); negative means never.
    task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_dly);
        int          sz;
        int          off;
        bit          bad_f3;
        bit          ill;
        bit          acked;
        int          len;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        longint      v;

        off    = int'(addr % 4);
        sz     = 1 << (f3 % 4);
        bad_f3 = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        ill    = bad_f3 || (off % sz != 0);
        if (we) begin
            exp_be = ((32'h1 << sz) - 1) << off;
            if (sz == 1)      exp_wd = (wd & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
            else              exp_wd = wd;
        end else begin
            exp_be = 32'hF;
            exp_wd = 32'h0;
        end
        acked = (ack_dly >= 0) && (ack_dly < int'(TO));
        len   = acked ? ack_dly + 1 : int'(TO);
        if (ill || !acked || we) begin
            exp_rd = 32'h0;
        end else begin
            v = longint'((rd >> (8 * off))) & ((64'sd1 <<< (8 * sz)) - 1);
            if (f3 < 4 && v >= (64'sd1 <<< (8 * sz - 1))) v = v - (64'sd1 <<< (8 * sz));
            exp_rd = v[31:0];
        end
        exp_err = ill || !acked;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        if (!ill) begin
            for (int k = 0; k < len; k++) begin
                // Garbage request while busy must be ignored.
                bus.req_valid  = 1'b1;
                bus.req_we     = 1'($urandom);
                bus.req_funct3 = 3'($urandom);
                bus.req_addr   = $urandom;
                bus.req_wdata  = $urandom;
                bus.mem_ack    = acked && (k == ack_dly);
                bus.mem_rdata  = (acked && k == ack_dly) ? rd : $urandom;
                chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'h1);
                chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
                chk({tag, "_early_valid"}, 32'(bus.resp_valid), 32'h0);
                chk({tag, "_mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk({tag, "_mem_be"}, 32'(bus.mem_be), exp_be);
                chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wd);
                chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(we));
                @(posedge clk);
                #1;
            end
        end
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'($urandom);
        bus.mem_rdata = $urandom;
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h1);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'(exp_err));
        chk({tag, "_resp_rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'h1);
        chk({tag, "_done_mem_req"}, 32'(bus.mem_req), 32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(bus.resp_valid), 32'h0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_hold_rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, "_hold_err"}, 32'(bus.resp_err), 32'(exp_err));
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_rdata", bus.resp_rdata, 32'h0);
        chk("reset_err", 32'(bus.resp_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_outputs("post_reset");

        // Directed cases
        run_txn("lb_neg",    1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AB_CD12, 1);
        run_txn("lhu",       1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h9234_5678, 0);
        run_txn("sb",        1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AB, 32'h0, 0);
        run_txn("sh_hi",     1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 2);
        run_txn("sw",        1'b1, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, 0);
        run_txn("lh_neg",    1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
        run_txn("lbu",       1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F000, 0);
        run_txn("lw_misal",  1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1111_1111, 0);
        run_txn("sh_misal",  1'b1, 3'b001, 32'h0000_0001, 32'h5555_5555, 32'h0, 0);
        run_txn("ld_f3_111", 1'b0, 3'b111, 32'h0000_0000, 32'h0, 32'h0, 0);
        run_txn("st_f3_100", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0);
        run_txn("lw_tmo",    1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h7777_7777, -1);
        run_txn("lw_ack4",   1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h7777_7777, 3);

        // Randomized transactions
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int          d;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d = int'($urandom_range(0, 5));
            if (d == 5) d = -1;
            run_txn("rand", 1'($urandom), 3'($urandom), a, $urandom, $urandom, d);
        end

        // Reset in the middle of an access
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0080;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        chk("abort_pre_req", 32'(bus.mem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_mem_req", 32'(bus.mem_req), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_valid", 32'(bus.resp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("abort_hold_valid", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_outputs("after_abort");
        run_txn("post_abort", 1'b0, 3'b001, 32'h0000_0086, 32'h0, 32'hA5A5_1234, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core datapath (ALU result and register read port 2) and a variable-latency data memory.
- Takes one load or store request per transaction and word-aligns the address.
- Generates byte enables, replicates store data across lanes, and extracts plus sign/zero-extends load data.
- Holds the core stalled until the memory acknowledges, the request faults, or a timeout expires.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT, 16, max cycles to wait for mem_ack before faulting; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core requests an access; sampled only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  DATA_WIDTH  byte address (ALU result)
- req_wdata  input  DATA_WIDTH  store data (register read port 2)
- busy  output  1  stall to the core; high whenever state != IDLE
- resp_valid  output  1  one-cycle pulse when the transaction completes
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and faults
- resp_err  output  1  set with resp_valid on misalign, illegal funct3 or timeout
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  DATA_WIDTH  word address: req_addr with [1:0] forced to 0
- mem_be  output  4  byte enables
- mem_wdata  output  DATA_WIDTH  lane-replicated store data
- mem_ack  input  1  memory completes; rdata valid the same cycle
- mem_rdata  input  DATA_WIDTH  raw word read data

Behaviour:
- Reset: state IDLE, all outputs 0, internal registers 0. Asserting rst mid-transaction aborts it immediately. mem_req drops asynchronously. No resp_valid is produced for the aborted access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, req_valid=1:
  - Latch we, funct3, addr, wdata.
  - If the request is legal, go to ACCESS.
  - If the request is illegal, go straight to DONE with err=1 and issue no memory access.
- Illegal request conditions:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 > 010.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata come from latched values and stay stable until ack.
  - On the edge where mem_ack=1: capture the extended load data, go to DONE.
  - Wait counter is cleared on entry and increments each cycle without ack.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: go to DONE with err=1 and rdata=0.
  - If ack and timeout coincide, ack wins and err=0.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Latency: a request accepted on edge N gives mem_req high from cycle N+1. With ack in that same cycle, resp_valid is high in cycle N+2. Maximum throughput is one transaction per 3 cycles.
- Ignored inputs: req_valid outside IDLE, and mem_ack outside ACCESS.
- resp_rdata and resp_err are held until the next accepted request.
- Byte enables and store data:
  - SB: mem_be = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: mem_be = 0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111, wdata unchanged.
  - Loads: mem_be = 1111, mem_wdata = 0.
- Load extraction: shift mem_rdata right by addr[1:0]*8, then apply the funct3 rule:
  - LB: sign-extend bit 7.
  - LBU: zero-extend from 8 bits.
  - LH: sign-extend bit 15.
  - LHU: zero-extend from 16 bits.
  - LW: use the word as-is.
- Stores return resp_rdata=0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants/enum (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
  - lsu_state_t enum {IDLE, ACCESS, DONE}.
  - Misalignment check function.
- Sub-module lsu_align (purely combinational):
  - Inputs: addr[1:0], funct3, we, wdata, raw rdata.
  - Outputs: mem_be, replicated wdata, extended rdata, misalign/illegal flag.
- Top level holds the FSM, latches and timeout counter.

Test Plan:
- LB, addr=0x0000_0103, mem_rdata=0x80AB_CD12, ack 1 cycle after mem_req -> mem_addr=0x0000_0100, mem_be=1111, resp_rdata=0xFFFF_FF80, resp_err=0, resp_valid in cycle N+3.
- LHU, addr=0x0000_0202, mem_rdata=0x9234_5678, zero-wait ack -> resp_rdata=0x0000_9234, resp_valid in cycle N+2, busy high in cycles N+1..N+2.
- SB, addr=0x0000_0011, wdata=0x1234_56AB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, resp_rdata=0, resp_err=0.
- LW, addr=0x0000_0006 -> mem_req never asserted, resp_valid in cycle N+1 with resp_err=1; SH at addr=0x0000_0001 gives the same result.
- TIMEOUT=4, LW at 0x0000_0040, mem_ack tied 0 -> mem_req high for 4 cycles, then resp_valid with resp_err=1, resp_rdata=0. A repeat run with ack in the 4th cycle -> resp_err=0.
- rst asserted during ACCESS -> mem_req and busy fall without waiting for a clock edge, no resp_valid. A new request after reset completes normally.
